instruction_fetch_unit: RTL and testbench

Fetches 32-bit instructions from the instruction memory, holds them in an instruction register, and presents the decoded fields to the control unit (OPCODE) and to the register file / immediate path (DEST, SRC1, SRC2_IMM). It sits directly upstream of the control unit. It owns the program counter, including sequential increment and the jump/branch target computed from the instruction's offset field. It handles a variable-latency memory through a busywait handshake and freezes on a downstream stall.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/pc_next_adder.sv | 22 ++
 rtl/instruction_fetch_unit.sv | 101 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: opcodes, instruction field
// positions and the fetch state encoding.
package cpu_pkg;

    localparam logic [7:0] OP_ADD   = 8'h00;
    localparam logic [7:0] OP_SUB   = 8'h01;
    localparam logic [7:0] OP_AND   = 8'h02;
    localparam logic [7:0] OP_OR    = 8'h03;
    localparam logic [7:0] OP_MOV   = 8'h04;
    localparam logic [7:0] OP_LOADI = 8'h05;
    localparam logic [7:0] OP_BEQ   = 8'h06;
    localparam logic [7:0] OP_J     = 8'h07;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 24;
    localparam int DEST_MSB   = 23;
    localparam int DEST_LSB   = 16;
    localparam int SRC1_MSB   = 15;
    localparam int SRC1_LSB   = 8;
    localparam int SRC2_MSB   = 7;
    localparam int SRC2_LSB   = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_t;

    // Signed word offset to a byte offset: sign-extend and scale by 4.
    function automatic logic [31:0] word_offset_bytes(input logic [7:0] offset);
        return {{22{offset[7]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_adder.sv
// Next-PC computation: sequential PC+4 or the relative jump/branch target
// (PC+4 plus a signed word offset). All arithmetic wraps modulo 2^32.
module pc_next_adder
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [7:0]  offset,
    input  logic        redirect,
    output logic [31:0] pc_next
);

    logic [31:0] pc_plus4;
    logic [31:0] target;

    // Both candidates are always computed; redirect only picks one.
    always_comb begin
        pc_plus4 = pc + 32'd4;
        target   = pc_plus4 + word_offset_bytes(offset);
        pc_next  = redirect ? target : pc_plus4;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time through a
// busywait handshake, holds it in IR and presents the decoded fields until
// the downstream stage accepts it.
//
// state   | meaning
// S_IDLE  | one cycle after reset, no request
// S_FETCH | read request at PC, waits out busywait, captures IR
// S_ISSUE | fields valid; holds while STALL, then advances PC
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
)
(
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    input  logic        STALL,
    input  logic        JUMP,
    input  logic        BRANCH_TAKEN,
    output logic [7:0]  OPCODE,
    output logic [7:0]  DEST,
    output logic [7:0]  SRC1,
    output logic [7:0]  SRC2_IMM,
    output logic        INSTR_VALID,
    output logic [31:0] PC_OUT
);

    // Low address bits are forced to zero so a misaligned parameter
    // cannot produce a misaligned fetch.
    localparam logic [31:0] PC_INIT = {PC_RESET[31:2], 2'b00};

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  ir;
    logic [31:0]  pc_next;
    logic         capture;
    logic         advance;

    // Redirect select is only meaningful in S_ISSUE; advance gates its use.
    pc_next_adder u_pc_next_adder (
        .pc       (pc),
        .offset   (ir[DEST_MSB:DEST_LSB]),
        .redirect (JUMP | BRANCH_TAKEN),
        .pc_next  (pc_next)
    );

    // Handshake qualifiers derived from the current state.
    always_comb begin
        capture = (state == S_FETCH) && !IMEM_BUSYWAIT;
        advance = (state == S_ISSUE) && !STALL;
    end

    // Fetch sequencing FSM.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state <= S_FETCH;
                S_FETCH: if (capture) state <= S_ISSUE;
                S_ISSUE: if (advance) state <= S_FETCH;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Instruction register: loaded only when memory completes a read.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ir <= '0;
        end else if (capture) begin
            ir <= IMEM_READDATA;
        end
    end

    // Program counter: moves only when the issued instruction is accepted.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc <= PC_INIT;
        end else if (advance) begin
            pc <= pc_next;
        end
    end

    // Outputs come straight from state, PC and IR so reset clears them at once.
    always_comb begin
        IMEM_READ   = (state == S_FETCH);
        IMEM_ADDR   = pc;
        INSTR_VALID = (state == S_ISSUE);
        PC_OUT      = pc;
        OPCODE      = ir[OPCODE_MSB:OPCODE_LSB];
        DEST        = ir[DEST_MSB:DEST_LSB];
        SRC1        = ir[SRC1_MSB:SRC1_LSB];
        SRC2_IMM    = ir[SRC2_MSB:SRC2_LSB];
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    import cpu_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          busy;
        int          stall;
        logic        jstall;
        logic        jmp;
        logic        br;
        logic [31:0] next;
    } step_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } issue_t;

    logic        CLK = 1'b0;
    logic        rst0_n, read0, busy0, stall0, jump0, br0, valid0;
    logic [31:0] addr0, rdata0, pcout0;
    logic [7:0]  op0, dest0, src10, src20;

    logic        rst1_n, read1, busy1, stall1, jump1, br1, valid1;
    logic [31:0] addr1, rdata1, pcout1;
    logic [7:0]  op1, dest1, src11, src21;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    step_t  steps[9];
    issue_t exp_issue[$];
    logic [31:0] exp_fetch[$];
    int     start_cyc[$];
    issue_t cur_issue;
    logic [31:0] cur_fetch;
    logic   prev_read = 1'b0;
    logic   prev_valid = 1'b0;

    always #5 CLK = ~CLK;

    instruction_fetch_unit #(.PC_RESET(32'h0000_0000)) dut0 (
        .CLK(CLK), .RESET_N(rst0_n), .IMEM_READ(read0), .IMEM_ADDR(addr0),
        .IMEM_READDATA(rdata0), .IMEM_BUSYWAIT(busy0), .STALL(stall0),
        .JUMP(jump0), .BRANCH_TAKEN(br0), .OPCODE(op0), .DEST(dest0),
        .SRC1(src10), .SRC2_IMM(src20), .INSTR_VALID(valid0), .PC_OUT(pcout0)
    );

    instruction_fetch_unit #(.PC_RESET(32'hFFFF_FFFC)) dut1 (
        .CLK(CLK), .RESET_N(rst1_n), .IMEM_READ(read1), .IMEM_ADDR(addr1),
        .IMEM_READDATA(rdata1), .IMEM_BUSYWAIT(busy1), .STALL(stall1),
        .JUMP(jump1), .BRANCH_TAKEN(br1), .OPCODE(op1), .DEST(dest1),
        .SRC1(src11), .SRC2_IMM(src21), .INSTR_VALID(valid1), .PC_OUT(pcout1)
    );

    function automatic logic [31:0] mem0(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h0504_0000;
            32'd4:   return 32'h0003_0102;
            32'd8:   return 32'h0201_0203;
            32'd12:  return 32'h0303_0405;
            32'd16:  return 32'h06FE_0000;
            32'd20:  return 32'h0703_0000;
            32'd36:  return 32'h0411_2233;
            default: return 32'h0000_0000;
        endcase
    endfunction

    assign rdata0 = mem0(addr0);
    assign rdata1 = {OP_SUB, 24'h01_0203};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expectations when the DUT starts a fetch or an issue.
    always @(negedge CLK) begin
        cyc++;
        if (read0 && !prev_read) begin
            if (exp_fetch.size() == 0) begin
                check("fetch_unexpected", addr0, 32'hDEAD_BEEF);
            end else begin
                cur_fetch = exp_fetch.pop_front();
                check("fetch_addr", addr0, cur_fetch);
            end
        end else if (read0) begin
            check("fetch_addr_hold", addr0, cur_fetch);
        end
        if (valid0 && !prev_valid) begin
            start_cyc.push_back(cyc);
            if (exp_issue.size() == 0) begin
                check("issue_unexpected", pcout0, 32'hDEAD_BEEF);
            end else begin
                cur_issue = exp_issue.pop_front();
                check("issue_pc", pcout0, cur_issue.pc);
                check("issue_fields", {op0, dest0, src10, src20}, cur_issue.instr);
            end
        end else if (valid0) begin
            check("issue_pc_hold", pcout0, cur_issue.pc);
            check("issue_fields_hold", {op0, dest0, src10, src20}, cur_issue.instr);
        end
        prev_read  = read0;
        prev_valid = valid0;
    end

    task automatic run_step(input step_t s);
        int n;
        exp_issue.push_back('{pc: s.addr, instr: s.instr});
        exp_fetch.push_back(s.next);
        n = 0;
        while (!read0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("fetch_wait", {31'd0, read0}, 32'd1);
        for (int k = 0; k < s.busy; k++) begin
            busy0 = 1'b1;
            @(negedge CLK);
            check("busy_no_valid", {31'd0, valid0}, 32'd0);
        end
        busy0 = 1'b0;
        @(negedge CLK);
        check("issue_reached", {31'd0, valid0}, 32'd1);
        if (s.stall > 0) begin
            stall0 = 1'b1;
            jump0  = s.jstall;
            for (int k = 0; k < s.stall; k++) @(negedge CLK);
        end
        stall0 = 1'b0;
        jump0  = s.jmp;
        br0    = s.br;
        @(negedge CLK);
        jump0 = 1'b0;
        br0   = 1'b0;
    endtask

    initial begin
        steps[0] = '{32'd0,  32'h0504_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'd4};
        steps[1] = '{32'd4,  32'h0003_0102, 0, 0, 1'b0, 1'b0, 1'b0, 32'd8};
        steps[2] = '{32'd8,  32'h0201_0203, 3, 0, 1'b0, 1'b0, 1'b0, 32'd12};
        steps[3] = '{32'd12, 32'h0303_0405, 0, 2, 1'b1, 1'b0, 1'b0, 32'd16};
        steps[4] = '{32'd16, 32'h06FE_0000, 0, 0, 1'b0, 1'b0, 1'b1, 32'd12};
        steps[5] = '{32'd12, 32'h0303_0405, 0, 0, 1'b0, 1'b0, 1'b0, 32'd16};
        steps[6] = '{32'd16, 32'h06FE_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'd20};
        steps[7] = '{32'd20, 32'h0703_0000, 0, 0, 1'b0, 1'b1, 1'b0, 32'd36};
        steps[8] = '{32'd36, 32'h0411_2233, 0, 0, 1'b0, 1'b0, 1'b0, 32'd40};

        rst0_n = 1'b0; busy0 = 1'b0; stall0 = 1'b0; jump0 = 1'b0; br0 = 1'b0;
        rst1_n = 1'b0; busy1 = 1'b0; stall1 = 1'b0; jump1 = 1'b0; br1 = 1'b0;

        // Reset held for 3 cycles; everything reads zero.
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("rst_read", {31'd0, read0}, 32'd0);
            check("rst_valid", {31'd0, valid0}, 32'd0);
            check("rst_fields", {op0, dest0, src10, src20}, 32'd0);
            check("rst_pc", pcout0, 32'd0);
        end
        exp_fetch.push_back(32'd0);
        rst0_n = 1'b1;
        @(negedge CLK);
        check("first_read", {31'd0, read0}, 32'd1);
        check("first_addr", addr0, 32'd0);

        for (int i = 0; i < 9; i++) run_step(steps[i]);
        busy0 = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("issue_count", start_cyc.size(), 32'd9);
        if (start_cyc.size() >= 5) begin
            check("period_zero_wait", start_cyc[1] - start_cyc[0], 32'd2);
            check("period_busy3", start_cyc[2] - start_cyc[1], 32'd5);
            check("period_stall2", start_cyc[4] - start_cyc[3], 32'd4);
        end
        check("issue_q_empty", exp_issue.size(), 32'd0);
        check("fetch_q_empty", exp_fetch.size(), 32'd0);

        // Wrap-around instance and asynchronous reset mid-fetch.
        rst1_n = 1'b1;
        @(negedge CLK);
        check("wrap_first_read", {31'd0, read1}, 32'd1);
        check("wrap_first_addr", addr1, 32'hFFFF_FFFC);
        @(negedge CLK);
        check("wrap_valid", {31'd0, valid1}, 32'd1);
        check("wrap_pc_out", pcout1, 32'hFFFF_FFFC);
        check("wrap_opcode", {24'd0, op1}, {24'd0, OP_SUB});
        @(negedge CLK);
        check("wrap_next_read", {31'd0, read1}, 32'd1);
        check("wrap_next_addr", addr1, 32'd0);
        busy1 = 1'b1;
        @(negedge CLK);
        #2 rst1_n = 1'b0;
        #1;
        check("async_rst_read", {31'd0, read1}, 32'd0);
        check("async_rst_valid", {31'd0, valid1}, 32'd0);
        check("async_rst_pc", addr1, 32'hFFFF_FFFC);
        check("async_rst_fields", {op1, dest1, src11, src21}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
